lifo_arbiter: RTL

- Shares one lifo instance between NUM_REQ requesters, issuing one push or pop per clock with round-robin fairness.
- Supports an optional per-requester lock so a requester can run an atomic push/pop sequence; the lock has a timeout.
- Tracks LIFO occupancy internally, rejects overflow/underflow before it reaches the LIFO, and routes pop data back to the issuing requester.
- Sits between client blocks and the lifo's clk/rst/data_wr/wr_en/rd_en/data_rd/lifo_full/lifo_empty interface.

---
 rtl/lifo_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/lifo_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO arbiter: op encodings, lock states and
// the occupancy counter width helper.
package lifo_pkg;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Counter must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first masked request at or above ptr, with wrap.
// Purely combinational so callers decide when the pointer advances.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic [NUM_REQ-1:0]         mask,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] masked;

    assign masked = req & mask;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && masked[(int'(ptr) + i) % NUM_REQ]) begin
                any = 1'b1;
                idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between NUM_REQ requesters: round-robin grant, optional
// lock with idle timeout, occupancy-based overflow/underflow rejection.
module lifo_arbiter
    import lifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 12,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_op,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            lifo_wr_en,
    output logic                            lifo_rd_en,
    output logic [DATA_WIDTH-1:0]           lifo_data_wr,
    input  logic [DATA_WIDTH-1:0]           lifo_data_rd,
    input  logic                            lifo_full,
    input  logic                            lifo_empty,
    output logic [occ_width(DEPTH)-1:0]     occupancy,
    output logic                            locked,
    output logic                            lock_timeout,
    output logic                            flag_mismatch
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int OCC_W = occ_width(DEPTH);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    lock_state_e        state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   idle_cnt, idle_nxt;
    logic               timeout_hit;

    logic [NUM_REQ-1:0] arb_mask;
    logic [IDX_W-1:0]   arb_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    logic               accept;
    logic               is_full, is_empty;
    logic               push_ok, pop_ok, op_err;
    logic               rsp_pop;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // While locked, the arbiter sees only the owner; searching from the owner
    // keeps the unlocked and locked paths on the same picker.
    assign arb_mask = (state == LOCKED) ? (NUM_REQ'(1) << owner) : '1;
    assign arb_ptr  = (state == LOCKED) ? owner : rr_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .mask  (arb_mask),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign accept    = rst & win_any;
    assign req_ready = rst ? grant : '0;

    assign is_full  = (occupancy == OCC_W'(DEPTH));
    assign is_empty = (occupancy == '0);

    assign push_ok = accept && (req_op[win_idx] == OP_PUSH) && !is_full;
    assign pop_ok  = accept && (req_op[win_idx] == OP_POP)  && !is_empty;
    assign op_err  = accept && !push_ok && !pop_ok;

    assign lifo_wr_en   = push_ok;
    assign lifo_rd_en   = pop_ok;
    assign lifo_data_wr = push_ok ? req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // LIFO read data lands one cycle after rd_en, aligned with the response.
    assign rsp_data = rsp_pop ? lifo_data_rd : '0;

    assign locked       = (state == LOCKED);
    assign lock_timeout = timeout_hit;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        idle_nxt    = idle_cnt;
        timeout_hit = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (accept) begin
                    rr_ptr_nxt = inc_wrap(win_idx);
                    if (req_lock[win_idx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = win_idx;
                        idle_nxt  = '0;
                    end
                end
            end
            LOCKED: begin
                if (!req_lock[owner] && (accept || !req_valid[owner])) begin
                    state_nxt  = UNLOCKED;
                    rr_ptr_nxt = inc_wrap(owner);
                    idle_nxt   = '0;
                end else if (accept) begin
                    idle_nxt = '0;
                end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = UNLOCKED;
                    rr_ptr_nxt  = inc_wrap(owner);
                    idle_nxt    = '0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= UNLOCKED;
            owner         <= '0;
            rr_ptr        <= '0;
            idle_cnt      <= '0;
            occupancy     <= '0;
            rsp_valid     <= '0;
            rsp_err       <= 1'b0;
            rsp_pop       <= 1'b0;
            flag_mismatch <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            idle_cnt <= idle_nxt;
            if (push_ok)
                occupancy <= occupancy + 1'b1;
            else if (pop_ok)
                occupancy <= occupancy - 1'b1;
            rsp_valid <= accept ? grant : '0;
            rsp_err   <= op_err;
            rsp_pop   <= pop_ok;
            if ((lifo_full != is_full) || (lifo_empty != is_empty))
                flag_mismatch <= 1'b1;
        end
    end

endmodule
